spi_slave: RTL and testbench

Synthesizable SPI slave that is the far end of the team's SPI master bus-functional model. It runs in a single system clock domain, oversamples `sclk`, `mosi` and `ss`, and exchanges `data_width`-bit words full-duplex with the master. Parallel words move in and out through a valid/ready transmit port and a pulsed receive port. It sits between an SPI pin group and register or stream logic.

---
 rtl/spi_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_slave.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave, oversampled in the clk domain, full-duplex data_width-bit words, one-word TX holding buffer.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to release miso (Z) whenever the slave is not ACTIVE.
`timescale 1ns/1ps
module spi_slave #(
  parameter int clk_polarity = 0,
  parameter int clk_phase    = 0,
  parameter int data_width   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic                  ss,
  input  logic [data_width-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [data_width-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);
  localparam int CW = $clog2(data_width + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [2:0]            ss_sync_q, ss_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [data_width-1:0] rx_shift_q, rx_shift_d;
  logic [data_width-1:0] tx_shift_q, tx_shift_d;
  logic [data_width-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic                  tx_armed_q, tx_armed_d;
  logic [data_width-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;

  logic sclk_rise, sclk_fall, leading_edge, trailing_edge;
  logic sample_edge, shift_edge, ss_fall, ss_rise, load;

  assign sclk_rise     = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall     = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign leading_edge  = (clk_polarity == 0) ? sclk_rise : sclk_fall;
  assign trailing_edge = (clk_polarity == 0) ? sclk_fall : sclk_rise;
  assign sample_edge   = (clk_phase == 0) ? leading_edge : trailing_edge;
  assign shift_edge    = (clk_phase == 0) ? trailing_edge : leading_edge;
  assign ss_fall       = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise       = ss_sync_q[1] & ~ss_sync_q[2];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    ss_sync_d   = {ss_sync_q[1:0], ss};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    tx_armed_d  = tx_armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        tx_armed_d = 1'b0;
        if (ss_fall) begin
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: begin
        if (ss_rise) begin
          // A word that completed on this same cycle is still delivered.
          if (bit_cnt_q == CW'(data_width)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
          state_d    = IDLE;
          bit_cnt_d  = '0;
          tx_armed_d = 1'b0;
        end else if (bit_cnt_q == CW'(data_width)) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          bit_cnt_d  = '0;
          load       = 1'b1;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[data_width-2:0], mosi_sync_q[1]};
            bit_cnt_d  = bit_cnt_q + CW'(1);
          end
          // The first shift edge of a word only presents the MSB (CPHA=1);
          // with CPHA=0 it is the stray trailing edge after the previous word.
          if (shift_edge) begin
            if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[data_width-2:0], 1'b0};
            else                 tx_armed_d = 1'b1;
          end
        end
      end
    endcase

    if (load) begin
      tx_shift_d = tx_full_q ? tx_buf_q : '0;
      tx_armed_d = 1'b0;
      tx_full_d  = 1'b0;
    end
    // Handshake only happens while empty, so a same-cycle load already saw the old contents.
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    miso_d = (state_q == ACTIVE && (clk_phase == 0 || tx_armed_q)) ?
             tx_shift_q[data_width-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {3{1'(clk_polarity)}};
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      tx_armed_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_armed_q  <= tx_armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign tx_ready = ~tx_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = busy ? miso_q : 1'bz;
`else
  assign miso = busy ? miso_q : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one DUT per CPOL/CPHA mode (index = 2*CPOL + CPHA), master modelled by tasks.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk [4];
  logic        mosi [4];
  logic        ss [4];
  logic        miso [4];
  logic        tx_valid [4];
  logic        tx_ready [4];
  logic        rx_valid [4];
  logic        busy [4];
  logic [15:0] tx_data [4];
  logic [15:0] rx_data [4];

  int          checks = 0;
  int          failures = 0;
  int          rx_cnt [4] = '{0, 0, 0, 0};
  logic [15:0] rx_last [4];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      spi_slave #(
        .clk_polarity(gi / 2),
        .clk_phase   (gi % 2),
        .data_width  (16)
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk[gi]),
        .mosi    (mosi[gi]),
        .miso    (miso[gi]),
        .ss      (ss[gi]),
        .tx_data (tx_data[gi]),
        .tx_valid(tx_valid[gi]),
        .tx_ready(tx_ready[gi]),
        .rx_data (rx_data[gi]),
        .rx_valid(rx_valid[gi]),
        .busy    (busy[gi])
      );
    end
  endgenerate

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i] === 1'b1) begin
        rx_cnt[i]  = rx_cnt[i] + 1;
        rx_last[i] = rx_data[i];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input int m, input logic [15:0] d);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready[m] !== 1'b1) begin
      failures++;
      $display("FAIL push_tx_timeout mode=%0d tx_ready=%b required 1", m, tx_ready[m]);
    end else begin
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
    end
  endtask

  task automatic frame_start(input int m);
    ss[m] = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic frame_end(input int m);
    wait_clk(HALF);
    ss[m] = 1'b1;
    wait_clk(HALF + 4);
  endtask

  // Master side of nbits bit-times, MSB first, returning what it sampled on miso.
  task automatic xfer(input int m, input logic [15:0] dout, input int nbits,
                      output logic [15:0] din);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    din = 16'h0000;
    for (int i = 15; i > 15 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = dout[i];
        wait_clk(HALF);
        din[i]  = miso[m];
        sclk[m] = ~cpol;
        wait_clk(HALF);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = dout[i];
        wait_clk(HALF);
        din[i]  = miso[m];
        sclk[m] = cpol;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic test_reset;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (miso[m] !== 1'b0 || tx_ready[m] !== 1'b1 || rx_valid[m] !== 1'b0 ||
          rx_data[m] !== 16'h0000 || busy[m] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values mode=%0d miso=%b tx_ready=%b rx_valid=%b rx_data=%h busy=%b required 0 1 0 0000 0",
                 m, miso[m], tx_ready[m], rx_valid[m], rx_data[m], busy[m]);
      end
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_basic;
    logic [15:0] rd;
    int base;
    base = rx_cnt[0];
    push_tx(0, 16'hA5C3);
    checks++;
    if (tx_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_tx_ready_full got=%b required 0", tx_ready[0]);
    end
    frame_start(0);
    checks++;
    if (tx_ready[0] !== 1'b1 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_ss_fall tx_ready=%b busy=%b required 1 1", tx_ready[0], busy[0]);
    end
    xfer(0, 16'h1234, 16, rd);
    frame_end(0);
    checks++;
    if (rd !== 16'hA5C3) begin
      failures++;
      $display("FAIL basic_miso got=%h required a5c3", rd);
    end
    checks++;
    if (rx_last[0] !== 16'h1234 || rx_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL basic_rx rx_data=%h pulses=%0d required 1234 1", rx_last[0], rx_cnt[0] - base);
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_after got=%b required 0", busy[0]);
    end
  endtask

  task automatic test_modes;
    logic [15:0] rd;
    int base;
    for (int m = 0; m < 4; m++) begin
      base = rx_cnt[m];
      push_tx(m, 16'h8001);
      frame_start(m);
      xfer(m, 16'hFFFE, 16, rd);
      frame_end(m);
      checks++;
      if (rd !== 16'h8001) begin
        failures++;
        $display("FAIL mode_miso mode=%0d got=%h required 8001", m, rd);
      end
      checks++;
      if (rx_last[m] !== 16'hFFFE || rx_cnt[m] - base !== 1) begin
        failures++;
        $display("FAIL mode_rx mode=%0d rx_data=%h pulses=%0d required fffe 1", m, rx_last[m], rx_cnt[m] - base);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd1, rd2;
    int base;
    base = rx_cnt[0];
    push_tx(0, 16'h1111);
    frame_start(0);
    push_tx(0, 16'h2222);
    xfer(0, 16'h0F0F, 16, rd1);
    checks++;
    if (rx_last[0] !== 16'h0F0F || rx_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL b2b_rx_first rx_data=%h pulses=%0d required 0f0f 1", rx_last[0], rx_cnt[0] - base);
    end
    xfer(0, 16'hF0F0, 16, rd2);
    frame_end(0);
    checks++;
    if (rd1 !== 16'h1111 || rd2 !== 16'h2222) begin
      failures++;
      $display("FAIL b2b_miso got=%h,%h required 1111,2222", rd1, rd2);
    end
    checks++;
    if (rx_last[0] !== 16'hF0F0 || rx_cnt[0] - base !== 2) begin
      failures++;
      $display("FAIL b2b_rx_second rx_data=%h pulses=%0d required f0f0 2", rx_last[0], rx_cnt[0] - base);
    end
  endtask

  task automatic test_underrun;
    logic [15:0] rd;
    checks++;
    if (tx_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL underrun_buffer_empty tx_ready=%b required 1", tx_ready[0]);
    end
    frame_start(0);
    xfer(0, 16'hBEEF, 16, rd);
    frame_end(0);
    checks++;
    if (rd !== 16'h0000 || rx_last[0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL underrun miso=%h rx_data=%h required 0000 beef", rd, rx_last[0]);
    end
  endtask

  task automatic test_abort;
    logic [15:0] rd;
    int base;
    base = rx_cnt[0];
    frame_start(0);
    xfer(0, 16'hFFFF, 7, rd);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before got=%b required 1", busy[0]);
    end
    ss[0] = 1'b1;
    wait_clk(3);
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_fall got=%b required 0 within 3 cycles", busy[0]);
    end
    wait_clk(20);
    checks++;
    if (rx_cnt[0] - base !== 0) begin
      failures++;
      $display("FAIL abort_no_rx_valid pulses=%0d required 0", rx_cnt[0] - base);
    end
    frame_start(0);
    xfer(0, 16'h5555, 16, rd);
    frame_end(0);
    checks++;
    if (rx_last[0] !== 16'h5555 || rx_cnt[0] - base !== 1) begin
      failures++;
      $display("FAIL abort_next_frame rx_data=%h pulses=%0d required 5555 1", rx_last[0], rx_cnt[0] - base);
    end
  endtask

  task automatic test_reset_mid_word;
    logic [15:0] rd;
    push_tx(0, 16'h0F0F);
    frame_start(0);
    xfer(0, 16'h1234, 8, rd);
    mosi[0] = 1'b0;
    wait_clk(HALF);
    sclk[0] = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (miso[0] !== 1'b0 || tx_ready[0] !== 1'b1 || rx_valid[0] !== 1'b0 ||
        rx_data[0] !== 16'h0000 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_word miso=%b tx_ready=%b rx_valid=%b rx_data=%h busy=%b required 0 1 0 0000 0",
               miso[0], tx_ready[0], rx_valid[0], rx_data[0], busy[0]);
    end
    sclk[0] = 1'b0;
    ss[0]   = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    push_tx(0, 16'h3C5A);
    frame_start(0);
    xfer(0, 16'h6789, 16, rd);
    frame_end(0);
    checks++;
    if (rd !== 16'h3C5A || rx_last[0] !== 16'h6789) begin
      failures++;
      $display("FAIL reset_recovery miso=%h rx_data=%h required 3c5a 6789", rd, rx_last[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      sclk[i]     = (i >= 2);
      mosi[i]     = 1'b0;
      ss[i]       = 1'b1;
      tx_valid[i] = 1'b0;
      tx_data[i]  = 16'h0000;
    end
    test_reset;
    test_basic;
    test_modes;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_reset_mid_word;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
